fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, issues word requests to instruction memory, and fills the IF/ID pipeline register. The decode stage, including immediate generation, reads `if_id_instr` from it. It handles hazard-unit stalls through a one-entry skid buffer and handles branch/jump redirects from execute, including redirects that arrive while a memory request is still outstanding.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_skid_buffer.sv | 34 +++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), used for killed or empty IF/ID slots.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int width = 32
) ();

  logic             req;
  logic [width-1:0] addr;
  logic             ack;
  logic [width-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that arrives while decode is stalled.
module fetch_skid_buffer #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             unload,
  input  logic             clear,
  input  logic [width-1:0] load_instr,
  input  logic [width-1:0] load_pc,
  output logic             full,
  output logic [width-1:0] instr,
  output logic [width-1:0] pc
);

  // Clear beats load (redirect kills the word), load beats unload (they never coincide).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request FSM, redirect draining and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               width    = 32,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [width-1:0]   redirect_pc,
  output logic               if_id_valid,
  output logic [width-1:0]   if_id_instr,
  output logic [width-1:0]   if_id_pc
);

  localparam logic [width-1:0] NOP  = width'(NOP_INSTR);
  localparam logic [width-1:0] INCR = width'(PC_INCR);

  fetch_state_t     state;
  logic [width-1:0] pc;
  logic [width-1:0] pending;

  logic             req;
  logic             accept;
  logic             skid_full;
  logic [width-1:0] skid_instr;
  logic [width-1:0] skid_pc;

  // Request depends only on registered state, never on the incoming ack.
  // DRAIN keeps the stale request asserted because it is still owed an ack.
  assign req      = ((state == FETCH) && !skid_full) || (state == DRAIN);
  assign accept   = (state == FETCH) && req && imem.ack;
  assign imem.req  = req;
  assign imem.addr = pc;

  fetch_skid_buffer #(
    .width (width)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept && stall && !redirect),
    .unload     (!redirect && !stall && skid_full),
    .clear      (redirect),
    .load_instr (imem.rdata),
    .load_pc    (pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Fetch FSM with PC and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) pc <= redirect_pc;
        end
        FETCH: begin
          if (redirect) begin
            if (req && !imem.ack) begin
              pending <= redirect_pc;
              state   <= DRAIN;
            end else begin
              pc <= redirect_pc;
            end
          end else if (accept) begin
            pc <= pc + INCR;
          end
        end
        DRAIN: begin
          if (redirect) begin
            if (imem.ack) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end else begin
              pending <= redirect_pc;
            end
          end else if (imem.ack) begin
            pc    <= pending;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IF/ID register: redirect kills, stall holds, skid drains before new memory words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc    <= '0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
    end else if (!stall) begin
      if (skid_full) begin
        if_id_valid <= 1'b1;
        if_id_instr <= skid_instr;
        if_id_pc    <= skid_pc;
      end else if (accept) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem.rdata;
        if_id_pc    <= pc;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_TB = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  fetch_stage_if #(.width(32)) imem ();

  fetch_stage #(
    .width    (32),
    .RESET_PC (RESET_PC_TB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch progress plus a queue standing in for the skid entry.
  bit          mStarted;
  bit          mDraining;
  logic [31:0] mPc;
  logic [31:0] mPend;
  bit          mValid;
  logic [31:0] mInstr;
  logic [31:0] mIfPc;
  logic [63:0] skidQ[$];

  // Memory model state.
  int memLat;
  int waitCnt;
  bit strayAck;
  bit randLat;

  function automatic logic [31:0] wordOf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mStarted  = 0;
    mDraining = 0;
    mPc       = RESET_PC_TB;
    mPend     = 0;
    mValid    = 0;
    mInstr    = NOP;
    mIfPc     = 0;
    skidQ.delete();
    waitCnt   = 0;
  endtask

  function automatic bit modelReq();
    return mStarted && (mDraining || (skidQ.size() == 0));
  endfunction

  task automatic checkAll();
    checkOutput("imem_req", 32'(imem.req), 32'(modelReq()));
    checkOutput("imem_addr", imem.addr, mPc);
    checkOutput("if_id_valid", 32'(if_id_valid), 32'(mValid));
    checkOutput("if_id_instr", if_id_instr, mInstr);
    if (mValid) checkOutput("if_id_pc", if_id_pc, mIfPc);
  endtask

  // One cycle: check outputs, answer imem, drive controls, advance model, wait for next negedge.
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc);
    bit          expReq;
    bit          ack;
    bit          acc;
    logic [31:0] rdata;
    logic [31:0] pcOld;
    checkAll();
    expReq = modelReq();
    ack    = 0;
    rdata  = $urandom;
    if (imem.req === 1'b1) begin
      if (waitCnt >= memLat) begin
        ack     = 1;
        rdata   = wordOf(imem.addr);
        waitCnt = 0;
        if (randLat) memLat = $urandom_range(0, 3);
      end else begin
        waitCnt++;
      end
    end
    if (strayAck) begin
      ack      = 1;
      strayAck = 0;
    end
    imem.ack    = ack;
    imem.rdata  = rdata;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;

    pcOld = mPc;
    acc   = mStarted && !mDraining && expReq && ack;
    if (rd) begin
      mValid = 0;
      mInstr = NOP;
      skidQ.delete();
      if (expReq && !ack) begin
        mDraining = 1;
        mPend     = rpc;
      end else begin
        mPc       = rpc;
        mDraining = 0;
      end
      mStarted = 1;
    end else begin
      if (!mStarted) mStarted = 1;
      else if (mDraining) begin
        if (ack) begin
          mPc       = mPend;
          mDraining = 0;
        end
      end else if (acc) mPc = mPc + 32'd4;
      if (st) begin
        if (acc) skidQ.push_back({rdata, pcOld});
      end else if (skidQ.size() > 0) begin
        {mInstr, mIfPc} = skidQ.pop_front();
        mValid = 1;
      end else if (acc) begin
        mInstr = rdata;
        mIfPc  = pcOld;
        mValid = 1;
      end else begin
        mValid = 0;
        mInstr = NOP;
      end
    end
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"}, 32'(imem.req), 32'd0);
    checkOutput({tag, "_addr"}, imem.addr, RESET_PC_TB);
    checkOutput({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    checkOutput({tag, "_instr"}, if_id_instr, NOP);
    checkOutput({tag, "_pc"}, if_id_pc, 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] wrapSeq[4];

  initial begin
    stall = 0; redirect = 0; redirect_pc = 0;
    imem.ack = 0; imem.rdata = 0;
    memLat = 0; strayAck = 0; randLat = 0;
    modelReset();
    wrapSeq[0] = 32'hFFFF_FFF8;
    wrapSeq[1] = 32'hFFFF_FFFC;
    wrapSeq[2] = 32'h0000_0000;
    wrapSeq[3] = 32'h0000_0004;

    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Zero-wait stream across the address wrap.
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrapAddr", imem.addr, wrapSeq[i]);
      applyStimulus(0, 0, 0);
    end
    repeat (4) applyStimulus(0, 0, 0);

    // Three-cycle stall mid-stream.
    repeat (3) applyStimulus(1, 0, 0);
    repeat (4) applyStimulus(0, 0, 0);

    // Slow memory, redirect in the request's second cycle.
    memLat = 3;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 32'h100);
    repeat (2) applyStimulus(0, 0, 0);
    checkOutput("drainTarget", imem.addr, 32'h100);
    checkOutput("drainValid", 32'(if_id_valid), 32'd0);
    repeat (6) applyStimulus(0, 0, 0);

    // Redirect coinciding with an ack while stalled.
    memLat = 0;
    repeat (3) applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 32'h40);
    checkOutput("ackRedirAddr", imem.addr, 32'h40);
    checkOutput("ackRedirInstr", if_id_instr, NOP);
    repeat (4) applyStimulus(0, 0, 0);

    // Asynchronous reset while draining.
    memLat = 3;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 32'h200);
    applyStimulus(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");
    imem.ack = 0; stall = 0; redirect = 0; redirect_pc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    memLat   = 0;
    strayAck = 1;
    applyStimulus(0, 0, 0);
    checkOutput("restartAddr", imem.addr, RESET_PC_TB);
    repeat (4) applyStimulus(0, 0, 0);

    // Random traffic with varying memory latency.
    randLat = 1;
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                    $urandom & 32'hFFFF_FFFC);
    end
    checkAll();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
